consmax_out_collector: RTL and testbench

// - Sits directly downstream of consmax: captures its BUS_NUM-lane 8-bit exp outputs, which have no backpressure.
// - Buffers them in a FIFO, tags end-of-row and streams them to the attention-value path over a valid/ready port.
// - Buffer overflow is detected and held as a sticky status bit.

---
 rtl/consmax_out_collector.sv | 252 +++++++++++++++++++++++++
 tb/tb_consmax_out_collector.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/consmax_out_collector.sv
// ---------------------------------------------------------------------------
// consmax_out_collector
//
// Purpose:
//   Captures the BUS_NUM-lane exp words that consmax produces. consmax cannot
//   be stalled, so every word is pushed into a small FIFO and drained over a
//   valid/ready port. Each word is tagged with an end-of-row flag. If a word
//   arrives while the FIFO is full and no pop happens in the same cycle, the
//   word is dropped and a sticky overflow flag is set. Row framing keeps
//   counting through dropped words.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_fixed_data       BUS_NUM x FIXED_BIT lane data from consmax
//   in_fixed_data_vld   per-lane valid; a word is present when any bit is set
//   cfg_row_len         words per row (0 is treated as 1)
//   cfg_vld             loads the row length, restarts the row and clears
//                       overflow; moves the block from IDLE to RUN
//   out_data/out_mask   FIFO head word and its lane mask (zero when empty)
//   out_last            head word is the last word of its row
//   out_vld / out_rdy   output handshake
//   overflow            sticky flag: a word was dropped because the FIFO was full
//   fifo_cnt            current FIFO occupancy
//   out_row_sum         (only with CONSMAX_COL_ROW_SUM_EN) saturating sum of
//                       the masked lane bytes in the row; non-zero only on
//                       the out_last word
//
// Build option:
//   CONSMAX_COL_ROW_SUM_EN  adds the out_row_sum port and its accumulator.
// ---------------------------------------------------------------------------
module consmax_out_collector #(
  parameter int unsigned FIXED_BIT      = 8,
  parameter int unsigned BUS_NUM        = 8,
  parameter int unsigned DATA_NUM_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [BUS_NUM*FIXED_BIT-1:0]        in_fixed_data,
  input  logic [BUS_NUM-1:0]                  in_fixed_data_vld,
  input  logic [DATA_NUM_WIDTH-1:0]           cfg_row_len,
  input  logic                                cfg_vld,
  output logic [BUS_NUM*FIXED_BIT-1:0]        out_data,
  output logic [BUS_NUM-1:0]                  out_mask,
  output logic                                out_last,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic                                overflow,
`ifdef CONSMAX_COL_ROW_SUM_EN
  output logic [FIXED_BIT+DATA_NUM_WIDTH+$clog2(BUS_NUM)-1:0] out_row_sum,
`endif
  output logic [$clog2(FIFO_DEPTH):0]         fifo_cnt
);

  localparam int unsigned WORD_W = BUS_NUM * FIXED_BIT;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
`ifdef CONSMAX_COL_ROW_SUM_EN
  localparam int unsigned SUM_W  = FIXED_BIT + DATA_NUM_WIDTH + $clog2(BUS_NUM);
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One FIFO entry: the word payload plus its framing tags.
  typedef struct packed {
`ifdef CONSMAX_COL_ROW_SUM_EN
    logic [SUM_W-1:0]   row_sum;
`endif
    logic               last;
    logic [BUS_NUM-1:0] mask;
    logic [WORD_W-1:0]  data;
  } entry_t;

  state_e                    state_q, state_d;
  logic [DATA_NUM_WIDTH-1:0] row_len_q, row_len_d;
  logic [DATA_NUM_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic                      overflow_q, overflow_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  entry_t                    mem_q [FIFO_DEPTH];
`ifdef CONSMAX_COL_ROW_SUM_EN
  logic [SUM_W-1:0]          acc_q, acc_d;
  logic [SUM_W-1:0]          acc_base;
  logic [SUM_W-1:0]          word_sum;
  logic [SUM_W:0]            acc_sum;
  logic [SUM_W-1:0]          acc_sat;
`endif

  logic [WORD_W-1:0]         masked_data;
  logic [DATA_NUM_WIDTH-1:0] len_eff;
  logic [DATA_NUM_WIDTH-1:0] cnt_base;
  logic                      word_present;
  logic                      word_last;
  logic                      pop;
  logic                      wr_en;
  entry_t                    wr_entry;
  entry_t                    head;

  // Zero the lanes whose valid bit is low so the stored word is clean.
  always_comb begin
    masked_data = '0;
    for (int unsigned i = 0; i < BUS_NUM; i++) begin
      if (in_fixed_data_vld[i]) begin
        masked_data[i*FIXED_BIT +: FIXED_BIT] = in_fixed_data[i*FIXED_BIT +: FIXED_BIT];
      end
    end
  end

`ifdef CONSMAX_COL_ROW_SUM_EN
  // Sum of the masked lane bytes of the incoming word.
  always_comb begin
    word_sum = '0;
    for (int unsigned i = 0; i < BUS_NUM; i++) begin
      word_sum = word_sum + SUM_W'(masked_data[i*FIXED_BIT +: FIXED_BIT]);
    end
  end
`endif

  // Next-state logic: the FSM, row framing, FIFO pointers and overflow.
  always_comb begin
    state_d    = state_q;
    row_len_d  = row_len_q;
    row_cnt_d  = row_cnt_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_en      = 1'b0;
    wr_entry   = '0;
    len_eff    = row_len_q;
    cnt_base   = row_cnt_q;
`ifdef CONSMAX_COL_ROW_SUM_EN
    acc_d      = acc_q;
    acc_base   = acc_q;
    acc_sum    = '0;
    acc_sat    = '0;
`endif

    pop = (cnt_q != '0) && out_rdy;

    // A configuration takes effect before a word that arrives in the same cycle.
    if (cfg_vld) begin
      state_d    = ST_RUN;
      len_eff    = (cfg_row_len == '0) ? DATA_NUM_WIDTH'(1) : cfg_row_len;
      cnt_base   = '0;
      overflow_d = 1'b0;
`ifdef CONSMAX_COL_ROW_SUM_EN
      acc_base   = '0;
`endif
    end
    row_len_d = len_eff;
    row_cnt_d = cnt_base;
`ifdef CONSMAX_COL_ROW_SUM_EN
    acc_d     = acc_base;
`endif

    // Words that arrive before the first configuration are ignored.
    word_present = (|in_fixed_data_vld) && ((state_q == ST_RUN) || cfg_vld);
    word_last    = (cnt_base == (len_eff - DATA_NUM_WIDTH'(1)));

    if (word_present) begin
      // The row count advances even for a dropped word so row framing is preserved.
      row_cnt_d     = word_last ? '0 : (cnt_base + DATA_NUM_WIDTH'(1));
      wr_entry.data = masked_data;
      wr_entry.mask = in_fixed_data_vld;
      wr_entry.last = word_last;
`ifdef CONSMAX_COL_ROW_SUM_EN
      acc_sum = {1'b0, acc_base} + {1'b0, word_sum};
      acc_sat = acc_sum[SUM_W] ? '1 : acc_sum[SUM_W-1:0];
      wr_entry.row_sum = word_last ? acc_sat : '0;
      acc_d = word_last ? '0 : acc_sat;
`endif
      // A slot freed by a pop in the same cycle can be reused immediately.
      if ((cnt_q < CNT_W'(FIFO_DEPTH)) || pop) begin
        wr_en = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_en && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control and framing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_len_q  <= DATA_NUM_WIDTH'(1);
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef CONSMAX_COL_ROW_SUM_EN
      acc_q      <= '0;
`endif
    end else begin
      row_len_q  <= row_len_d;
      row_cnt_q  <= row_cnt_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef CONSMAX_COL_ROW_SUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  // FIFO storage: no reset is needed because an empty FIFO masks the outputs.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Outputs come only from flops. An empty FIFO drives zeros, so a reset
  // discards buffered words at once.
  assign head     = mem_q[rd_ptr_q];
  assign out_vld  = (cnt_q != '0);
  assign out_data = out_vld ? head.data : '0;
  assign out_mask = out_vld ? head.mask : '0;
  assign out_last = out_vld ? head.last : 1'b0;
  assign overflow = overflow_q;
  assign fifo_cnt = cnt_q;
`ifdef CONSMAX_COL_ROW_SUM_EN
  assign out_row_sum = out_vld ? head.row_sum : '0;
`endif

endmodule

// File: tb/tb_consmax_out_collector.sv
// ---------------------------------------------------------------------------
// tb_consmax_out_collector
//
// Directed, self-checking bench for consmax_out_collector using the default
// parameters (8 lanes of 8 bits, FIFO depth 8). Inputs change 1 time unit
// after a rising clock edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_consmax_out_collector;

  localparam int unsigned FB = 8;
  localparam int unsigned BN = 8;
  localparam int unsigned DW = 10;
  localparam int unsigned FD = 8;
`ifdef CONSMAX_COL_ROW_SUM_EN
  localparam int unsigned SW = FB + DW + 3;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BN*FB-1:0]  in_fixed_data;
  logic [BN-1:0]     in_fixed_data_vld;
  logic [DW-1:0]     cfg_row_len;
  logic              cfg_vld;
  logic [BN*FB-1:0]  out_data;
  logic [BN-1:0]     out_mask;
  logic              out_last;
  logic              out_vld;
  logic              out_rdy;
  logic              overflow;
  logic [3:0]        fifo_cnt;
`ifdef CONSMAX_COL_ROW_SUM_EN
  logic [SW-1:0]     out_row_sum;
`endif

  int checks = 0;
  int errors = 0;

  consmax_out_collector #(
    .FIXED_BIT      (FB),
    .BUS_NUM        (BN),
    .DATA_NUM_WIDTH (DW),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_fixed_data     (in_fixed_data),
    .in_fixed_data_vld (in_fixed_data_vld),
    .cfg_row_len       (cfg_row_len),
    .cfg_vld           (cfg_vld),
    .out_data          (out_data),
    .out_mask          (out_mask),
    .out_last          (out_last),
    .out_vld           (out_vld),
    .out_rdy           (out_rdy),
    .overflow          (overflow),
`ifdef CONSMAX_COL_ROW_SUM_EN
    .out_row_sum       (out_row_sum),
`endif
    .fifo_cnt          (fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BN*FB-1:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", out_vld); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
    checks++; if (out_mask !== '0) begin errors++; $display("FAIL reset_mask: got %h expected 0", out_mask); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", fifo_cnt); end
    rst_n = 1'b1;
    // Words presented before any configuration are ignored.
    in_fixed_data = rep(8'hAA); in_fixed_data_vld = 8'hFF;
    tick();
    checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL idle_ignore_cnt: got %0d expected 0", fifo_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL idle_ignore_ovf: got %b expected 0", overflow); end
    in_fixed_data_vld = '0;
    cfg_row_len = 10'd4; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL cfg_vld_out: got %b expected 0", out_vld); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL cfg_ovf: got %b expected 0", overflow); end
    checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL cfg_cnt: got %0d expected 0", fifo_cnt); end
  endtask

  task automatic test_row_order();
    out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_fixed_data = rep(8'h10 + 8'(k)); in_fixed_data_vld = 8'hFF;
      tick();
      checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL row_vld[%0d]: got %b expected 1", k, out_vld); end
      checks++; if (out_data !== rep(8'h10 + 8'(k))) begin errors++; $display("FAIL row_data[%0d]: got %h expected %h", k, out_data, rep(8'h10 + 8'(k))); end
      checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL row_last[%0d]: got %b expected %b", k, out_last, (k == 3)); end
      checks++; if (fifo_cnt !== 4'd1) begin errors++; $display("FAIL row_cnt[%0d]: got %0d expected 1", k, fifo_cnt); end
    end
    in_fixed_data_vld = '0;
    tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL row_drained: got %b expected 0", out_vld); end
  endtask

  task automatic test_overflow();
    out_rdy = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      in_fixed_data = rep(8'(k)); in_fixed_data_vld = 8'hFF;
      tick();
      if (k == 8) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full: got %b expected 0", overflow); end
      end
    end
    in_fixed_data_vld = '0;
    checks++; if (fifo_cnt !== 4'd8) begin errors++; $display("FAIL ovf_cnt: got %0d expected 8", fifo_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    out_rdy = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      checks++; if (out_data !== rep(8'(j))) begin errors++; $display("FAIL ovf_drain_data[%0d]: got %h expected %h", j, out_data, rep(8'(j))); end
      checks++; if (out_last !== (j % 4 == 0)) begin errors++; $display("FAIL ovf_drain_last[%0d]: got %b expected %b", j, out_last, (j % 4 == 0)); end
      tick();
    end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL ovf_lost_words: got vld %b expected 0", out_vld); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    cfg_row_len = 10'd4; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_mask();
    out_rdy = 1'b1;
    in_fixed_data = rep(8'hFF); in_fixed_data_vld = 8'b0000_0101;
    tick();
    in_fixed_data_vld = '0;
    checks++; if (out_mask !== 8'h05) begin errors++; $display("FAIL mask_mask: got %h expected 05", out_mask); end
    checks++; if (out_data !== 64'h0000_0000_00FF_00FF) begin errors++; $display("FAIL mask_data: got %h expected 00000000_00ff00ff", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL mask_last: got %b expected 0", out_last); end
    tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mask_drained: got %b expected 0", out_vld); end
  endtask

  task automatic test_full_push_pop();
    out_rdy = 1'b0;
    cfg_row_len = 10'd4;
    for (int k = 0; k < 8; k++) begin
      cfg_vld = (k == 0);
      in_fixed_data = rep(8'h20 + 8'(k)); in_fixed_data_vld = 8'hFF;
      tick();
    end
    cfg_vld = 1'b0;
    checks++; if (fifo_cnt !== 4'd8) begin errors++; $display("FAIL fpp_fill_cnt: got %0d expected 8", fifo_cnt); end
    checks++; if (out_data !== rep(8'h20)) begin errors++; $display("FAIL fpp_hold: got %h expected %h", out_data, rep(8'h20)); end
    in_fixed_data = rep(8'h28); out_rdy = 1'b1;
    tick();
    in_fixed_data_vld = '0;
    checks++; if (fifo_cnt !== 4'd8) begin errors++; $display("FAIL fpp_cnt: got %0d expected 8", fifo_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", overflow); end
    for (int k = 1; k <= 8; k++) begin
      checks++; if (out_data !== rep(8'h20 + 8'(k))) begin errors++; $display("FAIL fpp_data[%0d]: got %h expected %h", k, out_data, rep(8'h20 + 8'(k))); end
      checks++; if (out_last !== (k == 3 || k == 7)) begin errors++; $display("FAIL fpp_last[%0d]: got %b expected %b", k, out_last, (k == 3 || k == 7)); end
      tick();
    end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL fpp_drained: got %b expected 0", out_vld); end
  endtask

  task automatic test_cfg_edges();
    out_rdy = 1'b1;
    // A row length of 0 is loaded as 1, so every word ends a row.
    cfg_row_len = 10'd0; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_fixed_data = rep(8'h31 + 8'(k)); in_fixed_data_vld = 8'hFF;
      tick();
      checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL len0_last[%0d]: got %b expected 1", k, out_last); end
    end
    // A configuration that arrives with a word makes that word count 0 of the new row.
    cfg_row_len = 10'd2; cfg_vld = 1'b1; in_fixed_data = rep(8'h41);
    tick();
    cfg_vld = 1'b0;
    checks++; if (out_last !== 1'b0 || out_data !== rep(8'h41)) begin errors++; $display("FAIL cfgword_first: got last %b data %h expected last 0 data %h", out_last, out_data, rep(8'h41)); end
    in_fixed_data = rep(8'h42);
    tick();
    in_fixed_data_vld = '0;
    checks++; if (out_last !== 1'b1 || out_data !== rep(8'h42)) begin errors++; $display("FAIL cfgword_second: got last %b data %h expected last 1 data %h", out_last, out_data, rep(8'h42)); end
    tick();
  endtask

`ifdef CONSMAX_COL_ROW_SUM_EN
  task automatic test_row_sum();
    out_rdy = 1'b0;
    cfg_row_len = 10'd2; cfg_vld = 1'b1;
    in_fixed_data = rep(8'h01); in_fixed_data_vld = 8'hFF;
    tick();
    cfg_vld = 1'b0;
    in_fixed_data = rep(8'h02);
    tick();
    in_fixed_data_vld = '0;
    checks++; if (out_row_sum !== SW'(0) || out_last !== 1'b0) begin errors++; $display("FAIL sum_first: got sum %0d last %b expected 0 0", out_row_sum, out_last); end
    out_rdy = 1'b1;
    tick();
    checks++; if (out_row_sum !== SW'(24) || out_last !== 1'b1) begin errors++; $display("FAIL sum_last: got sum %0d last %b expected 24 1", out_row_sum, out_last); end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    out_rdy = 1'b0;
    cfg_row_len = 10'd4; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_fixed_data = rep(8'h51 + 8'(k)); in_fixed_data_vld = 8'hFF;
      tick();
    end
    in_fixed_data_vld = '0;
    checks++; if (fifo_cnt !== 4'd2) begin errors++; $display("FAIL rstmid_pre_cnt: got %0d expected 2", fifo_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0 || fifo_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_flush: got vld %b cnt %0d expected 0 0", out_vld, fifo_cnt); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_data: got %h expected 0", out_data); end
    tick();
    rst_n = 1'b1;
    in_fixed_data = rep(8'h60); in_fixed_data_vld = 8'hFF;
    tick();
    tick();
    checks++; if (fifo_cnt !== 4'd0 || out_vld !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got cnt %0d vld %b expected 0 0", fifo_cnt, out_vld); end
    cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0; in_fixed_data_vld = '0;
    checks++; if (fifo_cnt !== 4'd1 || out_data !== rep(8'h60)) begin errors++; $display("FAIL rstmid_resume: got cnt %0d data %h expected 1 %h", fifo_cnt, out_data, rep(8'h60)); end
    out_rdy = 1'b1;
    tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rstmid_drain: got %b expected 0", out_vld); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_fixed_data = '0;
    in_fixed_data_vld = '0;
    cfg_row_len = '0;
    cfg_vld = 1'b0;
    out_rdy = 1'b0;
    test_reset();
    test_row_order();
    test_overflow();
    test_mask();
    test_full_push_pop();
    test_cfg_edges();
`ifdef CONSMAX_COL_ROW_SUM_EN
    test_row_sum();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
